// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the multi-filter row-stationary PE.
//   - FSM state encodings (3-bit constants)
//   - operating mode encodings
//   - acc_w(): accumulator width for a given word width and tap depth
// Build option: PE_SAT_EN (see pe_mac_unit) selects saturating output.
package pe_pkg;

  typedef logic [2:0] pe_state_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_FILT = 3'd1;
  localparam logic [2:0] ST_FILL      = 3'd2;
  localparam logic [2:0] ST_MAC       = 3'd3;
  localparam logic [2:0] ST_PSUM      = 3'd4;
  localparam logic [2:0] ST_EMIT      = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // Modes 2 and 3 are reserved and behave as MODE_CONV.
  localparam logic [1:0] MODE_CONV = 2'd0;
  localparam logic [1:0] MODE_PSUM = 2'd1;

  // Full product width plus enough headroom to sum FILT_DEPTH products.
  function automatic int acc_w(input int data_width, input int filt_depth);
    return 2 * data_width + $clog2(filt_depth);
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// pe_mac_unit: signed multiply-accumulate with output narrowing.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   mac_en          accumulate ifmap_word * filt_word this cycle
//   mac_first       with mac_en: load the product instead of adding (starts a filter)
//   ifmap_word      signed ifmap operand
//   filt_word       signed filter tap
//   psum_add        add sign-extended psum_word to the accumulator
//   psum_word       signed upstream partial sum
//   result          accumulator narrowed to DATA_WIDTH
// Build option: PE_SAT_EN defined -> result saturates to the signed DATA_WIDTH
// range; undefined -> result is the low DATA_WIDTH bits (wrap).
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FILT_DEPTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mac_en,
  input  logic                         mac_first,
  input  logic signed [DATA_WIDTH-1:0] ifmap_word,
  input  logic signed [DATA_WIDTH-1:0] filt_word,
  input  logic                         psum_add,
  input  logic signed [DATA_WIDTH-1:0] psum_word,
  output logic signed [DATA_WIDTH-1:0] result
);

  localparam int ACC_W  = acc_w(DATA_WIDTH, FILT_DEPTH);
  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  psum_ext;
  logic signed [ACC_W-1:0]  acc;

  assign prod     = PROD_W'(ifmap_word) * PROD_W'(filt_word);
  assign prod_ext = ACC_W'(prod);
  assign psum_ext = ACC_W'(psum_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= mac_first ? prod_ext : acc + prod_ext;
    end else if (psum_add) begin
      acc <= acc + psum_ext;
    end
  end

`ifdef PE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  always_comb begin
    result = acc[DATA_WIDTH-1:0];
    if (acc > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:DATA_WIDTH];
  assign result        = acc[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/pe_multi_filter_conv.sv
// pe_multi_filter_conv: row-stationary PE running a 1-D convolution of one
// tagged ifmap stream against NUM_FILT locally stored filters, each window
// reused across all filters, with optional upstream psum accumulation.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   start, mode, filter_size, stride run configuration, latched on start in IDLE
//   inp_buf_filter/valid_filter/read_en_filter_buf   filter word source
//   inp_buf_ifmap/valid_ifmap/read_en_ifmap_buf      {start_tag, end_tag, data}
//   inp_buf_psum/valid_psum_buf/read_en_psum_buf     psum word source
//   ready/out_buf/write_en_buf       result sink
//   stall                            waiting on an empty source or ready low
//   done_out                         one-cycle pulse at end of stream
// Build option: PE_SAT_EN selects saturating output narrowing (pe_mac_unit).
//
// state     | meaning
// IDLE      | wait for start, latch configuration
// LOAD_FILT | pop NUM_FILT x filter_size filter taps
// FILL      | pop ifmap words (drop stride overshoot first) until a window is held
// MAC       | one tap per cycle for the current filter
// PSUM      | add one upstream psum word (mode 1 only)
// EMIT      | push the narrowed result; after last filter slide the window
// DONE      | pulse done_out, clear the scratchpad
module pe_multi_filter_conv
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IFMAP_DEPTH = 12,
  parameter int FILT_DEPTH  = 10,
  parameter int NUM_FILT    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [1:0]                            mode,
  input  logic [$clog2(FILT_DEPTH+1)-1:0]       filter_size,
  input  logic [$clog2(IFMAP_DEPTH+1)-1:0]      stride,
  input  logic signed [DATA_WIDTH-1:0]          inp_buf_filter,
  input  logic                                  valid_filter,
  output logic                                  read_en_filter_buf,
  input  logic [DATA_WIDTH+1:0]                 inp_buf_ifmap,
  input  logic                                  valid_ifmap,
  output logic                                  read_en_ifmap_buf,
  input  logic signed [DATA_WIDTH-1:0]          inp_buf_psum,
  input  logic                                  valid_psum_buf,
  output logic                                  read_en_psum_buf,
  input  logic                                  ready,
  output logic signed [DATA_WIDTH-1:0]          out_buf,
  output logic                                  write_en_buf,
  output logic                                  stall,
  output logic                                  done_out
);

  localparam int FS_W  = $clog2(FILT_DEPTH + 1);
  localparam int ST_W  = $clog2(IFMAP_DEPTH + 1);
  localparam int PTR_W = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
  localparam int FI_W  = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int FM_W  = (NUM_FILT * FILT_DEPTH > 1) ? $clog2(NUM_FILT * FILT_DEPTH) : 1;

  // Circular pointer advance; off never exceeds IFMAP_DEPTH so one wrap suffices.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input logic [ST_W-1:0]  off);
    int sum;
    sum = int'(base) + int'(off);
    if (sum >= IFMAP_DEPTH) sum = sum - IFMAP_DEPTH;
    return PTR_W'(sum);
  endfunction

  pe_state_t         state;
  logic              psum_mode;
  logic [FS_W-1:0]   fsize;
  logic [ST_W-1:0]   stride_r;
  logic [FI_W-1:0]   f_idx;
  logic [FS_W-1:0]   t_idx;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ST_W-1:0]   count;
  logic [ST_W-1:0]   drop_cnt;
  logic              end_flag;

  logic signed [DATA_WIDTH-1:0] filt_mem [NUM_FILT*FILT_DEPTH];
  logic signed [DATA_WIDTH-1:0] ifm_mem  [IFMAP_DEPTH];

  logic [FS_W-1:0]   fsize_in;
  logic [ST_W-1:0]   stride_in;
  logic              ifm_start, ifm_end;
  logic [DATA_WIDTH-1:0] ifm_data;
  logic              fill_store;
  logic [PTR_W-1:0]  ifm_wr_ptr;
  logic [ST_W-1:0]   fill_count;
  logic [ST_W-1:0]   fsize_ext;
  logic              last_tap, last_filt;
  logic [FM_W-1:0]   filt_idx;
  logic [ST_W-1:0]   discard_n, drop_n, keep_cnt;

  assign fsize_in  = (filter_size > FS_W'(FILT_DEPTH)) ? FS_W'(FILT_DEPTH) : filter_size;
  assign stride_in = (stride == '0) ? ST_W'(1) : stride;

  assign ifm_start = inp_buf_ifmap[DATA_WIDTH+1];
  assign ifm_end   = inp_buf_ifmap[DATA_WIDTH];
  assign ifm_data  = inp_buf_ifmap[DATA_WIDTH-1:0];

  assign read_en_filter_buf = (state == ST_LOAD_FILT) && valid_filter;
  assign read_en_ifmap_buf  = (state == ST_FILL) && valid_ifmap;
  assign read_en_psum_buf   = (state == ST_PSUM) && valid_psum_buf;
  assign write_en_buf       = (state == ST_EMIT) && ready;
  assign done_out           = (state == ST_DONE);
  assign stall = ((state == ST_LOAD_FILT) && !valid_filter)   ||
                 ((state == ST_FILL)      && !valid_ifmap)    ||
                 ((state == ST_PSUM)      && !valid_psum_buf) ||
                 ((state == ST_EMIT)      && !ready);

  // A start_tag word restarts the window at the current read pointer,
  // overriding any pending stride overshoot.
  assign fill_store = read_en_ifmap_buf && (ifm_start || (drop_cnt == '0));
  assign ifm_wr_ptr = ifm_start ? rd_ptr : ptr_add(rd_ptr, count);
  assign fill_count = ifm_start ? ST_W'(1) : count + ST_W'(1);
  assign fsize_ext  = ST_W'(fsize);

  assign last_tap  = (t_idx == fsize - FS_W'(1));
  assign last_filt = (f_idx == FI_W'(NUM_FILT - 1));
  // Loading and MAC walk filters in the same order, so one index serves both.
  assign filt_idx  = FM_W'(int'(f_idx) * FILT_DEPTH + int'(t_idx));

  // Window slide: anything beyond the held words becomes incoming words to drop.
  assign discard_n = (stride_r >= count) ? count : stride_r;
  assign drop_n    = (stride_r >= count) ? stride_r - count : '0;
  assign keep_cnt  = count - discard_n;

  always_ff @(posedge clk) begin
    if (read_en_filter_buf) filt_mem[filt_idx] <= inp_buf_filter;
    if (fill_store)         ifm_mem[ifm_wr_ptr] <= ifm_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      psum_mode <= 1'b0;
      fsize     <= '0;
      stride_r  <= ST_W'(1);
      f_idx     <= '0;
      t_idx     <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      end_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            psum_mode <= (mode == MODE_PSUM);
            fsize     <= fsize_in;
            stride_r  <= stride_in;
            f_idx     <= '0;
            t_idx     <= '0;
            state     <= (fsize_in == '0) ? ST_DONE : ST_LOAD_FILT;
          end
        end
        ST_LOAD_FILT: begin
          if (valid_filter) begin
            if (last_tap) begin
              t_idx <= '0;
              if (last_filt) begin
                f_idx <= '0;
                state <= ST_FILL;
              end else begin
                f_idx <= f_idx + FI_W'(1);
              end
            end else begin
              t_idx <= t_idx + FS_W'(1);
            end
          end
        end
        ST_FILL: begin
          if (valid_ifmap) begin
            if (fill_store) begin
              count    <= fill_count;
              drop_cnt <= '0;
              end_flag <= ifm_start ? ifm_end : (end_flag | ifm_end);
              if (fill_count == fsize_ext) state <= ST_MAC;
              else if (ifm_end)            state <= ST_DONE;
            end else begin
              drop_cnt <= drop_cnt - ST_W'(1);
              if (ifm_end) begin
                end_flag <= 1'b1;
                state    <= ST_DONE;
              end
            end
          end
        end
        ST_MAC: begin
          if (last_tap) begin
            t_idx <= '0;
            state <= psum_mode ? ST_PSUM : ST_EMIT;
          end else begin
            t_idx <= t_idx + FS_W'(1);
          end
        end
        ST_PSUM: begin
          if (valid_psum_buf) state <= ST_EMIT;
        end
        ST_EMIT: begin
          if (ready) begin
            if (last_filt) begin
              f_idx    <= '0;
              rd_ptr   <= ptr_add(rd_ptr, discard_n);
              count    <= keep_cnt;
              drop_cnt <= drop_n;
              state    <= (end_flag && (keep_cnt < fsize_ext)) ? ST_DONE : ST_FILL;
            end else begin
              f_idx <= f_idx + FI_W'(1);
              state <= ST_MAC;
            end
          end
        end
        ST_DONE: begin
          rd_ptr   <= '0;
          count    <= '0;
          drop_cnt <= '0;
          end_flag <= 1'b0;
          f_idx    <= '0;
          t_idx    <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pe_mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .FILT_DEPTH (FILT_DEPTH)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .mac_en     (state == ST_MAC),
    .mac_first  (t_idx == '0),
    .ifmap_word (ifm_mem[ptr_add(rd_ptr, ST_W'(t_idx))]),
    .filt_word  (filt_mem[filt_idx]),
    .psum_add   (read_en_psum_buf),
    .psum_word  (inp_buf_psum),
    .result     (out_buf)
  );

endmodule

// File: tb/tb_pe_multi_filter_conv.sv
module tb_pe_multi_filter_conv;

  localparam int DW = 16;
  localparam int ID = 12;
  localparam int FD = 10;
  localparam int NF = 2;
  localparam int FS_W = $clog2(FD + 1);
  localparam int ST_W = $clog2(ID + 1);

  logic                 clk, rst, start;
  logic [1:0]           mode;
  logic [FS_W-1:0]      filter_size;
  logic [ST_W-1:0]      stride;
  logic signed [DW-1:0] inp_buf_filter;
  logic                 valid_filter, read_en_filter_buf;
  logic [DW+1:0]        inp_buf_ifmap;
  logic                 valid_ifmap, read_en_ifmap_buf;
  logic signed [DW-1:0] inp_buf_psum;
  logic                 valid_psum_buf, read_en_psum_buf;
  logic                 ready;
  logic signed [DW-1:0] out_buf;
  logic                 write_en_buf, stall, done_out;

  pe_multi_filter_conv #(
    .DATA_WIDTH(DW), .IFMAP_DEPTH(ID), .FILT_DEPTH(FD), .NUM_FILT(NF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .filter_size(filter_size), .stride(stride),
    .inp_buf_filter(inp_buf_filter), .valid_filter(valid_filter),
    .read_en_filter_buf(read_en_filter_buf),
    .inp_buf_ifmap(inp_buf_ifmap), .valid_ifmap(valid_ifmap),
    .read_en_ifmap_buf(read_en_ifmap_buf),
    .inp_buf_psum(inp_buf_psum), .valid_psum_buf(valid_psum_buf),
    .read_en_psum_buf(read_en_psum_buf),
    .ready(ready), .out_buf(out_buf), .write_en_buf(write_en_buf),
    .stall(stall), .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0]   filt_q[$];
  logic [DW+1:0]   ifm_q[$];
  logic [DW-1:0]   psum_q[$];
  int              exp_q[$];
  int              cur_filt[$];
  int              cur_ifm[$];
  int              cur_psum[$];

  bit gaps       = 1'b0;
  int ready_mode = 1;   // 0 random, 1 high, 2 low
  bit pend_f, pend_i, pend_p;

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int narrow(input longint a);
`ifdef PE_SAT_EN
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (a > hi) return int'(hi);
    if (a < lo) return int'(lo);
    return int'(a);
`else
    logic signed [DW-1:0] w;
    w = a[DW-1:0];
    return int'(w);
`endif
  endfunction

  // ---------------- source buffers ----------------
  initial begin
    valid_filter = 1'b0; inp_buf_filter = '0; pend_f = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_f && filt_q.size() > 0) void'(filt_q.pop_front());
      valid_filter   = (filt_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      inp_buf_filter = (filt_q.size() > 0) ? filt_q[0] : '0;
      #4;
      pend_f = valid_filter && read_en_filter_buf;
    end
  end

  initial begin
    valid_ifmap = 1'b0; inp_buf_ifmap = '0; pend_i = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_i && ifm_q.size() > 0) void'(ifm_q.pop_front());
      valid_ifmap   = (ifm_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      inp_buf_ifmap = (ifm_q.size() > 0) ? ifm_q[0] : '0;
      #4;
      pend_i = valid_ifmap && read_en_ifmap_buf;
    end
  end

  initial begin
    valid_psum_buf = 1'b0; inp_buf_psum = '0; pend_p = 1'b0;
    forever begin
      @(negedge clk);
      if (pend_p && psum_q.size() > 0) void'(psum_q.pop_front());
      valid_psum_buf = (psum_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      inp_buf_psum   = (psum_q.size() > 0) ? psum_q[0] : '0;
      #4;
      pend_p = valid_psum_buf && read_en_psum_buf;
    end
  end

  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       ready = ($urandom_range(0, 3) != 0);
        1:       ready = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (write_en_buf) begin
        check_eq("write_en_needs_ready", ready, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_output: got %0d, no output was expected", out_buf);
        end else begin
          check_eq("out_buf", $signed(out_buf), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Windows start at 0, s, 2s, ... while a full window fits in the stream;
  // each window yields one result per filter, in filter order.
  task automatic prepare_case(input int fs, input int st, input int md);
    int fse, ste, pi, n;
    longint acc;
    logic [DW-1:0] d;
    int v;
    fse = (fs > FD) ? FD : fs;
    ste = (st == 0) ? 1 : st;
    n   = cur_ifm.size();
    pi  = 0;
    if (fse > 0) begin
      for (int s = 0; s + fse <= n; s += ste) begin
        for (int f = 0; f < NF; f++) begin
          acc = 0;
          for (int t = 0; t < fse; t++)
            acc += longint'(cur_ifm[s+t]) * longint'(cur_filt[f*fse+t]);
          if (md == 1) begin
            acc += longint'(cur_psum[pi]);
            pi++;
          end
          exp_q.push_back(narrow(acc));
        end
      end
    end
    foreach (cur_filt[i]) begin
      v = cur_filt[i]; d = v[DW-1:0]; filt_q.push_back(d);
    end
    foreach (cur_ifm[i]) begin
      v = cur_ifm[i]; d = v[DW-1:0];
      ifm_q.push_back({(i == 0), (i == n - 1), d});
    end
    foreach (cur_psum[i]) begin
      v = cur_psum[i]; d = v[DW-1:0]; psum_q.push_back(d);
    end
    filter_size = FS_W'(fs);
    stride      = ST_W'(st);
    mode        = 2'(md);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_case(input string tag);
    int cyc;
    cyc = 0;
    while (!done_out && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, " done_out"}, done_out, 1);
    @(negedge clk);
    check_eq({tag, " done_pulse_width"}, done_out, 0);
    repeat (2) @(negedge clk);
    check_eq({tag, " outputs_left"}, exp_q.size(), 0);
    check_eq({tag, " ifmap_left"}, ifm_q.size(), 0);
    check_eq({tag, " filt_left"}, filt_q.size(), 0);
    check_eq({tag, " psum_left"}, psum_q.size(), 0);
  endtask

  task automatic run_case(input string tag, input int fs, input int st, input int md,
                          input bit reissue);
    prepare_case(fs, st, md);
    pulse_start();
    if (reissue && fs != 0) begin
      @(negedge clk);
      filter_size = FS_W'($urandom_range(0, 15));
      stride      = ST_W'($urandom_range(0, 15));
      mode        = 2'($urandom_range(0, 3));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    finish_case(tag);
  endtask

  task automatic set_base_case();
    cur_filt = '{1, 2, 3, -1, 0, 1};
    cur_ifm  = '{1, 2, 3, 4};
    cur_psum.delete();
  endtask

  task automatic random_case(input int idx);
    int r, fs, fse, st, md, n, nw;
    r = $urandom_range(0, 19);
    if (r == 0)      fs = 0;
    else if (r == 1) fs = $urandom_range(FD + 1, 13);
    else             fs = $urandom_range(1, FD);
    fse = (fs > FD) ? FD : fs;
    st  = $urandom_range(0, 6);
    md  = $urandom_range(0, 3);
    n   = (fse == 0) ? 0 : $urandom_range(1, fse + 10);
    nw  = (fse == 0 || n < fse) ? 0 : (n - fse) / ((st == 0) ? 1 : st) + 1;
    cur_filt.delete(); cur_ifm.delete(); cur_psum.delete();
    for (int i = 0; i < NF * fse; i++) cur_filt.push_back(int'($urandom_range(0, 65535)) - 32768);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) cur_ifm.push_back(int'($urandom_range(0, 65535)) - 32768);
      else                           cur_ifm.push_back(int'($urandom_range(0, 200)) - 100);
    end
    if (md == 1)
      for (int i = 0; i < nw * NF; i++) cur_psum.push_back(int'($urandom_range(0, 65535)) - 32768);
    gaps = 1'b1;
    ready_mode = 0;
    run_case($sformatf("rand%0d", idx), fs, st, md, 1'($urandom_range(0, 1)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; mode = '0; filter_size = '0; stride = '0;
    repeat (2) @(negedge clk);
    #3;
    check_eq("reset write_en_buf", write_en_buf, 0);
    check_eq("reset out_buf", out_buf, 0);
    check_eq("reset stall", stall, 0);
    check_eq("reset done_out", done_out, 0);
    check_eq("reset read_en_filter", read_en_filter_buf, 0);
    check_eq("reset read_en_ifmap", read_en_ifmap_buf, 0);
    check_eq("reset read_en_psum", read_en_psum_buf, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases, sources always valid and sink always ready.
    gaps = 1'b0; ready_mode = 1;
    set_base_case();
    run_case("conv_s1", 3, 1, 0, 1'b0);

    set_base_case();
    cur_ifm = '{1, 2, 3, 4, 5};
    run_case("conv_s2", 3, 2, 0, 1'b0);

    set_base_case();
    cur_psum = '{100, -100, 5, 5};
    run_case("psum", 3, 1, 1, 1'b0);

    cur_filt = '{32767, 1};
    cur_ifm  = '{2};
    cur_psum.delete();
    run_case("narrow", 1, 1, 0, 1'b0);

    cur_filt.delete(); cur_ifm.delete(); cur_psum.delete();
    run_case("fsize0", 0, 1, 0, 1'b0);

    set_base_case();
    run_case("stride0", 3, 0, 3, 1'b0);

    // Backpressure at the first EMIT.
    set_base_case();
    ready_mode = 2;
    prepare_case(3, 1, 0);
    pulse_start();
    cyc = 0;
    while (!stall && cyc < 200) begin
      @(negedge clk); #3; cyc++;
    end
    check_eq("bp reached_emit", stall, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #3;
      check_eq("bp write_en_buf", write_en_buf, 0);
      check_eq("bp stall", stall, 1);
      check_eq("bp out_buf", $signed(out_buf), 14);
    end
    ready_mode = 1;
    finish_case("bp");

    // Reset in the middle of MAC, then a fresh run.
    set_base_case();
    prepare_case(3, 1, 0);
    pulse_start();
    repeat (10) @(negedge clk);
    #2;
    check_eq("pre_reset out_buf_nonzero", (out_buf != 0), 1);
    rst = 1'b0;
    #1;
    check_eq("midrst write_en_buf", write_en_buf, 0);
    check_eq("midrst out_buf", out_buf, 0);
    check_eq("midrst stall", stall, 0);
    check_eq("midrst done_out", done_out, 0);
    check_eq("midrst read_en_ifmap", read_en_ifmap_buf, 0);
    check_eq("midrst read_en_filter", read_en_filter_buf, 0);
    filt_q.delete(); ifm_q.delete(); psum_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    set_base_case();
    run_case("after_rst", 3, 1, 0, 1'b0);

    for (int i = 0; i < 25; i++) random_case(i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
